// File: rtl/srt2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srt2_pkg
// Description : Shared definitions for the byte-serial radix-2 divider:
//               FSM state encoding, byte width, operand width limit, a
//               width-legality macro and a two's-complement magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef SRT2_WIDTH_LEGAL
`define SRT2_WIDTH_LEGAL(w) ((((w) % 8) == 0) && ((w) >= 8) && ((w) <= 64))
`endif

package srt2_pkg;

    localparam int BYTE_W = 8;
    localparam int MAX_W  = 64;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        PREP   = 3'd2,
        ITER   = 3'd3,
        FIX    = 3'd4,
        OUT    = 3'd5
    } srt2_state_t;

    // Magnitude of a w-bit two's-complement value held zero-extended in a
    // MAX_W container. The most negative value maps onto its own unsigned
    // magnitude, which is what the divider core needs.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                               input int unsigned     w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] res;
        mask = (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        res  = v[6'(w - 1)] ? (~v + 64'd1) : v;
        return res & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/srt2_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : srt2_iter_core
// Description : One combinational radix-2 non-restoring division step.
//               The next dividend bit is taken from the MSB of the quotient
//               shift register; the new quotient bit is the sign of the new
//               partial remainder (1 when non-negative).
// Ports       : i_rem     partial remainder, WIDTH+1 bits, two's complement
//               i_q       quotient / dividend shift register
//               i_divisor divisor magnitude
//               o_rem     next partial remainder
//               o_q       next quotient shift register
// Revision    : 1.0 - initial release
// ============================================================================
module srt2_iter_core
    import srt2_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_div_ext;

    // The doubled remainder may exceed WIDTH+1 bits transiently, but the
    // post-add/subtract result always lies in [-B, B), so modulo arithmetic
    // in WIDTH+1 bits is exact.
    assign w_shifted = {i_rem[WIDTH-1:0], i_q[WIDTH-1]};
    assign w_div_ext = {1'b0, i_divisor};
    assign o_rem     = i_rem[WIDTH] ? (w_shifted + w_div_ext) : (w_shifted - w_div_ext);
    assign o_q       = {i_q[WIDTH-2:0], ~o_rem[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/srt2_serial_div.sv
`default_nettype none
// ============================================================================
// Module      : srt2_serial_div
// Description : Byte-serial integer divider. Dividend then divisor are pushed
//               MSB byte first; WIDTH radix-2 non-restoring steps follow;
//               remainder then quotient are streamed out LSB byte first.
//               Supports unsigned and two's-complement signed operation with
//               divide-by-zero and signed-overflow flags.
// Ports       : clk       rising-edge clock
//               rst       asynchronous active-high reset
//               push_in   operand byte strobe
//               data_in   operand byte
//               sign      1 = signed; sampled with the first dividend byte
//               pull_out  one-cycle pulse ahead of the result byte stream
//               data_out  result byte stream
//               busy      operation in progress, inputs ignored
//               dz_flag   divisor was zero
//               ovf_flag  signed MIN / -1
// Revision    : 1.0 - initial release
// ============================================================================
module srt2_serial_div
    import srt2_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_in,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              sign,
    output logic              pull_out,
    output logic [BYTE_W-1:0] data_out,
    output logic              busy,
    output logic              dz_flag,
    output logic              ovf_flag
);

    localparam int NB      = WIDTH / BYTE_W;
    localparam int c_cnt_w = $clog2(2 * NB + 1);
    localparam int c_it_w  = $clog2(WIDTH + 1);

    localparam logic [c_cnt_w-1:0] c_last_load = c_cnt_w'(NB - 1);
    localparam logic [c_cnt_w-1:0] c_out_done  = c_cnt_w'(2 * NB);
    localparam logic [c_it_w-1:0]  c_last_iter = c_it_w'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_min       = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (!`SRT2_WIDTH_LEGAL(WIDTH)) begin : g_width_illegal
            $error("srt2_serial_div: WIDTH must be a multiple of 8 within 8..64");
        end
    endgenerate

    srt2_state_t          r_state;
    logic [c_cnt_w-1:0]   r_byte_cnt;
    logic [c_it_w-1:0]    r_iter_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_sign;
    logic [WIDTH-1:0]     r_bmag;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_q;
    logic                 r_qneg;
    logic                 r_rneg;
    logic                 r_dz;
    logic                 r_ovf;
    logic [2*WIDTH-1:0]   r_res;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_rem_step;
    logic [WIDTH-1:0]     w_q_step;
    logic [WIDTH-1:0]     w_rem_mag;
    logic [WIDTH-1:0]     w_q_signed;
    logic [WIDTH-1:0]     w_r_signed;
    logic [WIDTH-1:0]     w_q_final;
    logic [WIDTH-1:0]     w_r_final;

    assign w_a_mag = r_sign ? WIDTH'(abs_w(MAX_W'(r_a), WIDTH)) : r_a;
    assign w_b_mag = r_sign ? WIDTH'(abs_w(MAX_W'(r_b), WIDTH)) : r_b;

    srt2_iter_core #(
        .WIDTH     (WIDTH)
    ) u_iter_core (
        .i_rem     (r_rem),
        .i_q       (r_q),
        .i_divisor (r_bmag),
        .o_rem     (w_rem_step),
        .o_q       (w_q_step)
    );

    // Final restoration of a negative remainder; the true remainder lies in
    // [0, B), so WIDTH-bit arithmetic is sufficient.
    assign w_rem_mag  = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_bmag) : r_rem[WIDTH-1:0];
    assign w_q_signed = r_qneg ? -r_q : r_q;
    assign w_r_signed = r_rneg ? -w_rem_mag : w_rem_mag;

    // Special results override the iterated ones; r_a still holds the raw
    // dividend bits since it is not touched after loading.
    always_comb begin
        w_q_final = w_q_signed;
        w_r_final = w_r_signed;
        if (r_dz) begin
            w_q_final = '1;
            w_r_final = r_a;
        end else if (r_ovf) begin
            w_q_final = c_min;
            w_r_final = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= LOAD_A;
            r_byte_cnt <= '0;
            r_iter_cnt <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_sign     <= 1'b0;
            r_bmag     <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
            r_res      <= '0;
            pull_out   <= 1'b0;
            data_out   <= '0;
            busy       <= 1'b0;
            dz_flag    <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            pull_out <= 1'b0;
            case (r_state)
                LOAD_A: begin
                    if (push_in) begin
                        r_a <= (r_a << BYTE_W) | WIDTH'(data_in);
                        if (r_byte_cnt == '0) begin
                            r_sign   <= sign;
                            dz_flag  <= 1'b0;
                            ovf_flag <= 1'b0;
                        end
                        if (r_byte_cnt == c_last_load) begin
                            r_byte_cnt <= '0;
                            r_state    <= LOAD_B;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_cnt_w'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (push_in) begin
                        r_b <= (r_b << BYTE_W) | WIDTH'(data_in);
                        if (r_byte_cnt == c_last_load) begin
                            r_byte_cnt <= '0;
                            busy       <= 1'b1;
                            r_state    <= PREP;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_cnt_w'(1);
                        end
                    end
                end
                PREP: begin
                    r_q        <= w_a_mag;
                    r_bmag     <= w_b_mag;
                    r_rem      <= '0;
                    r_qneg     <= r_sign & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_rneg     <= r_sign & r_a[WIDTH-1];
                    r_dz       <= (r_b == '0);
                    r_ovf      <= r_sign & (r_a == c_min) & (r_b == '1);
                    r_iter_cnt <= '0;
                    r_state    <= ITER;
                end
                ITER: begin
                    r_rem <= w_rem_step;
                    r_q   <= w_q_step;
                    if (r_iter_cnt == c_last_iter) begin
                        r_state <= FIX;
                    end else begin
                        r_iter_cnt <= r_iter_cnt + c_it_w'(1);
                    end
                end
                FIX: begin
                    r_res      <= {w_q_final, w_r_final};
                    dz_flag    <= r_dz;
                    ovf_flag   <= r_ovf;
                    pull_out   <= 1'b1;
                    r_byte_cnt <= '0;
                    r_state    <= OUT;
                end
                OUT: begin
                    if (r_byte_cnt == c_out_done) begin
                        data_out   <= '0;
                        busy       <= 1'b0;
                        r_byte_cnt <= '0;
                        r_state    <= LOAD_A;
                    end else begin
                        data_out   <= r_res[BYTE_W-1:0];
                        r_res      <= r_res >> BYTE_W;
                        r_byte_cnt <= r_byte_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_srt2_serial_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_srt2_serial_div
// Description : Self-checking bench for srt2_serial_div at WIDTH=32 and 64:
//               directed vector table, reset/abort sequences and randomized
//               operands against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srt2_serial_div;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       push32, sign32, pull32, busy32, dz32, ovf32;
    logic [7:0] din32, dout32;
    logic       push64, sign64, pull64, busy64, dz64, ovf64;
    logic [7:0] din64, dout64;

    srt2_serial_div #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .push_in(push32), .data_in(din32), .sign(sign32),
        .pull_out(pull32), .data_out(dout32), .busy(busy32),
        .dz_flag(dz32), .ovf_flag(ovf32)
    );

    srt2_serial_div #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .push_in(push64), .data_in(din64), .sign(sign64),
        .pull_out(pull64), .data_out(dout64), .busy(busy64),
        .dz_flag(dz64), .ovf_flag(ovf64)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          w64;
        bit          s;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        bit          dz;
        bit          ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w64, input bit p, input logic [7:0] d, input bit sg);
        if (w64) begin
            push64 = p; din64 = d; sign64 = sg;
        end else begin
            push32 = p; din32 = d; sign32 = sg;
        end
    endtask

    // Arithmetic reference: plain integer division with the flag rules.
    function automatic void ref_div(input bit w64, input bit s,
                                    input logic [63:0] a_in, input logic [63:0] b_in,
                                    output logic [63:0] q, output logic [63:0] r,
                                    output bit dz, output bit ovf);
        logic [63:0] mask;
        logic [63:0] min_v;
        logic [63:0] a;
        logic [63:0] b;
        longint      sa;
        longint      sb;
        mask  = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        min_v = w64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        a = a_in & mask;
        b = b_in & mask;
        dz = 1'b0;
        ovf = 1'b0;
        if (b == 64'd0) begin
            dz = 1'b1; q = mask; r = a;
        end else if (s && a == min_v && b == mask) begin
            ovf = 1'b1; q = min_v; r = 64'd0;
        end else if (s) begin
            sa = w64 ? longint'(a) : longint'(signed'(a[31:0]));
            sb = w64 ? longint'(b) : longint'(signed'(b[31:0]));
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
        end else begin
            q = (a / b) & mask;
            r = (a % b) & mask;
        end
    endfunction

    // Loads one operation, then watches a bounded window of cycles. n counts
    // cycles after the one carrying the last divisor byte.
    task automatic run_op(input bit w64, input bit s, input logic [63:0] a, input logic [63:0] b,
                          input bit junk,
                          output logic [63:0] q, output logic [63:0] r, output bit dz, output bit ovf,
                          output int lat, output int pulls, output bit prot_ok);
        int         nb;
        int         wd;
        int         last;
        int         k;
        logic       po, bz, dzv, ovv;
        logic [7:0] dv;
        nb = w64 ? 8 : 4;
        wd = w64 ? 64 : 32;
        last = wd + 3 + 2 * nb;
        q = '0; r = '0; dz = 1'b0; ovf = 1'b0; lat = -1; pulls = 0; prot_ok = 1'b1;
        for (int i = 2 * nb - 1; i >= 0; i--) begin
            @(negedge clk);
            // sign is only meaningful on the first dividend byte
            drive(w64, 1'b1, (i >= nb) ? a[8*(i-nb) +: 8] : b[8*i +: 8],
                  (i == 2 * nb - 1) ? s : ~s);
        end
        for (int n = 1; n <= last + 1; n++) begin
            @(negedge clk);
            po  = w64 ? pull64 : pull32;
            bz  = w64 ? busy64 : busy32;
            dv  = w64 ? dout64 : dout32;
            dzv = w64 ? dz64   : dz32;
            ovv = w64 ? ovf64  : ovf32;
            if (n == 1 && bz !== 1'b1) prot_ok = 1'b0;
            if (po === 1'b1) begin
                pulls++;
                if (lat < 0) begin
                    lat = n; dz = dzv; ovf = ovv;
                end
            end
            if (n < wd + 4 && dv !== 8'h00) prot_ok = 1'b0;
            if (n >= wd + 4 && n <= last) begin
                k = n - wd - 4;
                if (k < nb) r[8*k +: 8] = dv;
                else        q[8*(k-nb) +: 8] = dv;
                if (bz !== 1'b1) prot_ok = 1'b0;
            end
            if (n == last + 1) begin
                if (bz !== 1'b0 || dv !== 8'h00) prot_ok = 1'b0;
                if (dzv !== dz || ovv !== ovf) prot_ok = 1'b0;
            end
            if (junk && n <= last) drive(w64, 1'b1, 8'($urandom), 1'($urandom));
            else                   drive(w64, 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic check_op(input string name, input bit w64, input bit s,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] eq, input logic [63:0] er,
                            input bit edz, input bit eovf, input bit junk);
        logic [63:0] q, r;
        bit          dz, ovf, prot_ok;
        int          lat, pulls;
        run_op(w64, s, a, b, junk, q, r, dz, ovf, lat, pulls, prot_ok);
        check({name, "_q"}, q, eq);
        check({name, "_r"}, r, er);
        check({name, "_dz"}, 64'(dz), 64'(edz));
        check({name, "_ovf"}, 64'(ovf), 64'(eovf));
        check({name, "_latency"}, 64'(lat), 64'(w64 ? 67 : 35));
        check({name, "_pulses"}, 64'(pulls), 64'd1);
        check({name, "_protocol"}, 64'(prot_ok), 64'd1);
    endtask

    function automatic logic [63:0] rand_opnd(input bit w64);
        logic [63:0] mask;
        logic [63:0] v;
        mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case ($urandom_range(0, 9))
            0:       v = 64'd0;
            1:       v = mask;
            2:       v = w64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            3:       v = 64'($urandom_range(1, 15));
            4:       v = mask - 64'($urandom_range(1, 15));
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ab, bb, eq, er;
        bit          edz, eovf, junk;
        int          viol;

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("rst32_pull", 64'(pull32), 64'd0);
        check("rst32_data", 64'(dout32), 64'd0);
        check("rst32_busy", 64'(busy32), 64'd0);
        check("rst32_flags", 64'({dz32, ovf32}), 64'd0);
        check("rst64_pull", 64'(pull64), 64'd0);
        check("rst64_busy_flags", 64'({busy64, dz64, ovf64, dout64}), 64'd0);
        rst = 1'b0;

        // w64, s, a, b, q, r, dz, ovf
        vecs.push_back('{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFD, 64'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 64'h12345678, 64'h0, 64'hFFFFFFFF, 64'h12345678, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 64'h0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 64'h80000000, 64'hFFFFFFFF, 64'h0, 64'h80000000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 64'h8000000000000001, 64'h2, 64'h4000000000000000, 64'h1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 64'h0, 64'h5, 64'h0, 64'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 64'h7, 64'hFFFFFFFE, 64'hFFFFFFFD, 64'h1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 64'hFFFFFFF9, 64'h0, 64'hFFFFFFFF, 64'hFFFFFFF9, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF9, 64'hFFFFFFFFFFFFFFFE, 64'h3,
                         64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
                         64'h8000000000000000, 64'h0, 1'b0, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].w64, vecs[i].s, vecs[i].a, vecs[i].b,
                     vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ovf, 1'b0);
        end

        // Reset clears a set dz_flag without any new operation.
        check_op("dz_before_rst", 1'b0, 1'b0, 64'h55, 64'h0, 64'hFFFFFFFF, 64'h55, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_clears_dz", 64'(dz32), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Abort during ITER with pushes arriving while busy.
        ab = 64'h12345678;
        bb = 64'h3;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            drive(1'b0, 1'b1, (i >= 4) ? ab[8*(i-4) +: 8] : bb[8*i +: 8], 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int n = 2; n <= 9; n++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 8'($urandom), 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("abort_busy_in_iter", 64'(busy32), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_outputs", 64'({pull32, busy32, dz32, ovf32, dout32}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        viol = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (pull32 !== 1'b0 || dout32 !== 8'h00 || busy32 !== 1'b0) viol++;
        end
        check("abort_no_stale_output", 64'(viol), 64'd0);

        // Partially loaded dividend is dropped by reset.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 8'hA5, 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_op("fresh_10_3", 1'b0, 1'b0, 64'd10, 64'd3, 64'd3, 64'd1, 1'b0, 1'b0, 1'b1);

        // Randomized operands against the reference model.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 300; i++) begin
                ab = rand_opnd(1'b0);
                bb = rand_opnd(1'b0);
                junk = ($urandom_range(0, 3) == 0);
                ref_div(1'b0, 1'(s), ab, bb, eq, er, edz, eovf);
                check_op($sformatf("rnd32_s%0d_%0d", s, i), 1'b0, 1'(s), ab, bb, eq, er, edz, eovf, junk);
            end
            for (int i = 0; i < 40; i++) begin
                ab = rand_opnd(1'b1);
                bb = rand_opnd(1'b1);
                junk = ($urandom_range(0, 3) == 0);
                ref_div(1'b1, 1'(s), ab, bb, eq, er, edz, eovf);
                check_op($sformatf("rnd64_s%0d_%0d", s, i), 1'b1, 1'(s), ab, bb, eq, er, edz, eovf, junk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
